// File: rtl/decode_regfile_pipe.sv
// Decode stage for the MIPS-style CPU: register file with write-back port and
// optional bypass, immediate decode, and a valid/ready ID/EX pipeline register.
module decode_regfile_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LINK_REG       = 31,
  parameter int BYPASS         = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [31:0]               id_instruction,
  input  logic [DATA_WIDTH-1:0]     id_pc_plus4,
  input  logic                      id_reg_dst,
  input  logic                      id_jal,
  input  logic                      id_reg_write,
  input  logic                      flush,
  input  logic                      wb_valid,
  input  logic                      wb_reg_write,
  input  logic                      wb_mem_to_reg,
  input  logic                      wb_jal,
  input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0]     wb_alu_result,
  input  logic [DATA_WIDTH-1:0]     wb_mem_data,
  input  logic [DATA_WIDTH-1:0]     wb_pc_plus4,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_WIDTH-1:0]     ex_read_data_1,
  output logic [DATA_WIDTH-1:0]     ex_read_data_2,
  output logic [DATA_WIDTH-1:0]     ex_imm_ext,
  output logic [REG_ADDR_WIDTH-1:0] ex_rs,
  output logic [REG_ADDR_WIDTH-1:0] ex_rt,
  output logic [REG_ADDR_WIDTH-1:0] ex_write_addr,
  output logic                      ex_reg_write,
  output logic [DATA_WIDTH-1:0]     ex_pc_plus4
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] LINK_ADDR = REG_ADDR_WIDTH'(LINK_REG);

  logic [DATA_WIDTH-1:0]     regs [NUM_REGS];
  logic                      we;
  logic [DATA_WIDTH-1:0]     wdata;

  logic [5:0]                opcode;
  logic [15:0]               imm;
  logic [REG_ADDR_WIDTH-1:0] rs;
  logic [REG_ADDR_WIDTH-1:0] rt;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0]     read_data_1;
  logic [DATA_WIDTH-1:0]     read_data_2;
  logic [DATA_WIDTH-1:0]     imm_ext;
  logic [REG_ADDR_WIDTH-1:0] write_addr;
  logic                      reg_write;
  logic signed [15:0]        imm_signed;
  logic signed [31:0]        lui_word;

  assign opcode     = id_instruction[31:26];
  assign imm        = id_instruction[15:0];
  assign rs         = REG_ADDR_WIDTH'(id_instruction[25:21]);
  assign rt         = REG_ADDR_WIDTH'(id_instruction[20:16]);
  assign rd         = REG_ADDR_WIDTH'(id_instruction[15:11]);
  assign imm_signed = imm;
  assign lui_word   = {imm, 16'h0000};

  // Writes to $0 are discarded here so the array entry stays at its reset value.
  assign we    = wb_valid & wb_reg_write & (wb_addr != '0);
  assign wdata = wb_jal ? wb_pc_plus4 : (wb_mem_to_reg ? wb_mem_data : wb_alu_result);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wb_addr] <= wdata;
    end
  end

  always_comb begin
    read_data_1 = regs[rs];
    if (rs == '0) begin
      read_data_1 = '0;
    end else if ((BYPASS != 0) && we && (wb_addr == rs)) begin
      read_data_1 = wdata;
    end
  end

  always_comb begin
    read_data_2 = regs[rt];
    if (rt == '0) begin
      read_data_2 = '0;
    end else if ((BYPASS != 0) && we && (wb_addr == rt)) begin
      read_data_2 = wdata;
    end
  end

  // Size casts of signed operands sign-extend, which covers LUI on wide datapaths.
  always_comb begin
    imm_ext = DATA_WIDTH'(imm_signed);
    case (opcode)
      6'h0C, 6'h0D, 6'h0E: imm_ext = DATA_WIDTH'(imm);
      6'h0F:               imm_ext = DATA_WIDTH'(lui_word);
      default:             imm_ext = DATA_WIDTH'(imm_signed);
    endcase
  end

  always_comb begin
    write_addr = rt;
    if (id_jal) begin
      write_addr = LINK_ADDR;
    end else if (id_reg_dst) begin
      write_addr = rd;
    end
    reg_write = id_reg_write & (write_addr != '0);
  end

  assign id_ready = !ex_valid | ex_ready;

  // Held operands track write-backs to their source registers so a long stall never
  // hands EX a stale value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_read_data_1 <= '0;
      ex_read_data_2 <= '0;
      ex_imm_ext     <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_write_addr  <= '0;
      ex_reg_write   <= 1'b0;
      ex_pc_plus4    <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (id_ready) begin
      ex_valid <= id_valid;
      if (id_valid) begin
        ex_read_data_1 <= read_data_1;
        ex_read_data_2 <= read_data_2;
        ex_imm_ext     <= imm_ext;
        ex_rs          <= rs;
        ex_rt          <= rt;
        ex_write_addr  <= write_addr;
        ex_reg_write   <= reg_write;
        ex_pc_plus4    <= id_pc_plus4;
      end
    end else begin
      if (we && (wb_addr == ex_rs) && (ex_rs != '0)) begin
        ex_read_data_1 <= wdata;
      end
      if (we && (wb_addr == ex_rt) && (ex_rt != '0)) begin
        ex_read_data_2 <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_decode_regfile_pipe.sv
// Directed bench for decode_regfile_pipe: immediate/destination vector table plus
// hand-written register file, bypass, stall, flush and reset sequences.
module tb_decode_regfile_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready, id_ready_nb;
  logic [31:0] id_instruction;
  logic [31:0] id_pc_plus4;
  logic        id_reg_dst, id_jal, id_reg_write;
  logic        flush;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg, wb_jal;
  logic [4:0]  wb_addr;
  logic [31:0] wb_alu_result, wb_mem_data, wb_pc_plus4;
  logic        ex_ready;

  logic        ex_valid, ex_valid_nb;
  logic [31:0] ex_read_data_1, ex_read_data_2, ex_imm_ext, ex_pc_plus4;
  logic [31:0] nb_read_data_1, nb_read_data_2, nb_imm_ext, nb_pc_plus4;
  logic [4:0]  ex_rs, ex_rt, ex_write_addr, nb_rs, nb_rt, nb_write_addr;
  logic        ex_reg_write, nb_reg_write;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  decode_regfile_pipe #(.BYPASS(1)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_instruction(id_instruction), .id_pc_plus4(id_pc_plus4), .id_reg_dst(id_reg_dst),
    .id_jal(id_jal), .id_reg_write(id_reg_write), .flush(flush), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_jal(wb_jal),
    .wb_addr(wb_addr), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_pc_plus4(wb_pc_plus4), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_read_data_1(ex_read_data_1), .ex_read_data_2(ex_read_data_2),
    .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_write_addr(ex_write_addr),
    .ex_reg_write(ex_reg_write), .ex_pc_plus4(ex_pc_plus4)
  );

  decode_regfile_pipe #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_ready(id_ready_nb),
    .id_instruction(id_instruction), .id_pc_plus4(id_pc_plus4), .id_reg_dst(id_reg_dst),
    .id_jal(id_jal), .id_reg_write(id_reg_write), .flush(flush), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_jal(wb_jal),
    .wb_addr(wb_addr), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
    .wb_pc_plus4(wb_pc_plus4), .ex_valid(ex_valid_nb), .ex_ready(ex_ready),
    .ex_read_data_1(nb_read_data_1), .ex_read_data_2(nb_read_data_2),
    .ex_imm_ext(nb_imm_ext), .ex_rs(nb_rs), .ex_rt(nb_rt), .ex_write_addr(nb_write_addr),
    .ex_reg_write(nb_reg_write), .ex_pc_plus4(nb_pc_plus4)
  );

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        reg_dst;
    logic        jal;
    logic        reg_write;
    logic [31:0] exp_imm;
    logic [4:0]  exp_waddr;
    logic        exp_rw;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [15:0] imm, input logic reg_dst, input logic jal,
                               input logic reg_write, input logic [31:0] pc);
    id_valid       = 1'b1;
    id_instruction = {op, rs, rt, imm};
    id_reg_dst     = reg_dst;
    id_jal         = jal;
    id_reg_write   = reg_write;
    id_pc_plus4    = pc;
  endtask

  task automatic setWriteBack(input logic valid, input logic [4:0] addr, input logic [31:0] alu,
                              input logic [31:0] mem, input logic [31:0] pc, input logic m2r,
                              input logic jal);
    wb_valid      = valid;
    wb_reg_write  = 1'b1;
    wb_addr       = addr;
    wb_alu_result = alu;
    wb_mem_data   = mem;
    wb_pc_plus4   = pc;
    wb_mem_to_reg = m2r;
    wb_jal        = jal;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = '{6'h08, 5'd2,  16'h8001, 1'b0, 1'b0, 1'b1, 32'hFFFF8001, 5'd2,  1'b1};
    vecs[1]  = '{6'h0D, 5'd2,  16'h8001, 1'b0, 1'b0, 1'b1, 32'h00008001, 5'd2,  1'b1};
    vecs[2]  = '{6'h0F, 5'd2,  16'h8001, 1'b0, 1'b0, 1'b1, 32'h80010000, 5'd2,  1'b1};
    vecs[3]  = '{6'h0C, 5'd4,  16'hFFFF, 1'b0, 1'b0, 1'b1, 32'h0000FFFF, 5'd4,  1'b1};
    vecs[4]  = '{6'h0E, 5'd6,  16'hF234, 1'b0, 1'b0, 1'b1, 32'h0000F234, 5'd6,  1'b1};
    vecs[5]  = '{6'h23, 5'd9,  16'h7FFF, 1'b0, 1'b0, 1'b1, 32'h00007FFF, 5'd9,  1'b1};
    vecs[6]  = '{6'h0F, 5'd1,  16'h7FFF, 1'b0, 1'b0, 1'b1, 32'h7FFF0000, 5'd1,  1'b1};
    vecs[7]  = '{6'h00, 5'd4,  16'h1800, 1'b1, 1'b0, 1'b1, 32'h00001800, 5'd3,  1'b1};
    vecs[8]  = '{6'h00, 5'd4,  16'h0040, 1'b1, 1'b0, 1'b1, 32'h00000040, 5'd0,  1'b0};
    vecs[9]  = '{6'h03, 5'd4,  16'hFFF0, 1'b1, 1'b1, 1'b1, 32'hFFFFFFF0, 5'd31, 1'b1};
    vecs[10] = '{6'h2B, 5'd12, 16'h0010, 1'b0, 1'b0, 1'b0, 32'h00000010, 5'd12, 1'b0};

    reset = 1'b1; id_valid = 1'b0; id_instruction = '0; id_pc_plus4 = '0;
    id_reg_dst = 1'b0; id_jal = 1'b0; id_reg_write = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    setWriteBack(1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    checkOutput("reset ex_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("reset read_data_1", ex_read_data_1, 32'h0);
    checkOutput("reset pc_plus4", ex_pc_plus4, 32'h0);
    checkOutput("reset id_ready", {31'b0, id_ready}, 32'h1);
    reset = 1'b0;
    step();

    // Vector table: immediate decode and destination resolution
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].op, 5'd0, vecs[i].rt, vecs[i].imm, vecs[i].reg_dst,
                    vecs[i].jal, vecs[i].reg_write, 32'h1000 + 32'(i * 4));
      step();
      checkOutput($sformatf("vec%0d ex_valid", i), {31'b0, ex_valid}, 32'h1);
      checkOutput($sformatf("vec%0d imm_ext", i), ex_imm_ext, vecs[i].exp_imm);
      checkOutput($sformatf("vec%0d write_addr", i), {27'b0, ex_write_addr}, {27'b0, vecs[i].exp_waddr});
      checkOutput($sformatf("vec%0d reg_write", i), {31'b0, ex_reg_write}, {31'b0, vecs[i].exp_rw});
      checkOutput($sformatf("vec%0d pc_plus4", i), ex_pc_plus4, 32'h1000 + 32'(i * 4));
    end

    // Write $5 then read it back; rt=0 must read zero
    id_valid = 1'b0;
    setWriteBack(1'b1, 5'd5, 32'h1234, 32'h9999, 32'h0, 1'b0, 1'b0);
    step();
    checkOutput("idle ex_valid", {31'b0, ex_valid}, 32'h0);
    wb_valid = 1'b0;
    applyStimulus(6'h00, 5'd5, 5'd0, 16'h0, 1'b1, 1'b0, 1'b1, 32'h4);
    step();
    checkOutput("rd $5", ex_read_data_1, 32'h1234);
    checkOutput("rd $0 rt", ex_read_data_2, 32'h0);
    checkOutput("ex_rs", {27'b0, ex_rs}, 32'd5);

    // Attempted write to $0, with a same-cycle read of $0
    setWriteBack(1'b1, 5'd0, 32'hFFFF, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(6'h00, 5'd0, 5'd0, 16'h0, 1'b1, 1'b0, 1'b1, 32'h8);
    step();
    checkOutput("$0 bypass", ex_read_data_1, 32'h0);
    wb_valid = 1'b0;
    step();
    checkOutput("$0 after write", ex_read_data_1, 32'h0);
    checkOutput("$0 after write nb", nb_read_data_1, 32'h0);

    // Same-cycle write-back and read of $7
    setWriteBack(1'b1, 5'd7, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(6'h00, 5'd7, 5'd7, 16'h0, 1'b1, 1'b0, 1'b1, 32'hC);
    step();
    checkOutput("bypass=1 rd $7", ex_read_data_1, 32'hDEADBEEF);
    checkOutput("bypass=1 rt $7", ex_read_data_2, 32'hDEADBEEF);
    checkOutput("bypass=0 rd $7", nb_read_data_1, 32'h0);
    wb_valid = 1'b0;
    step();
    checkOutput("bypass=0 rd $7 later", nb_read_data_1, 32'hDEADBEEF);

    // Write data selection: mem data, then JAL link overriding mem_to_reg
    setWriteBack(1'b1, 5'd8, 32'h1111, 32'hCAFE, 32'h0, 1'b1, 1'b0);
    id_valid = 1'b0;
    step();
    setWriteBack(1'b1, 5'd31, 32'h2222, 32'h3333, 32'h400, 1'b1, 1'b1);
    step();
    wb_valid = 1'b0;
    applyStimulus(6'h03, 5'd8, 5'd31, 16'h0, 1'b1, 1'b1, 1'b1, 32'h10);
    step();
    checkOutput("mem_to_reg $8", ex_read_data_1, 32'hCAFE);
    checkOutput("jal link $31", ex_read_data_2, 32'h400);
    checkOutput("jal write_addr", {27'b0, ex_write_addr}, 32'd31);
    checkOutput("jal reg_write", {31'b0, ex_reg_write}, 32'h1);

    // Stall: slot holds, rt operand refreshes from write-back
    applyStimulus(6'h00, 5'd5, 5'd9, 16'h0, 1'b1, 1'b0, 1'b1, 32'h100);
    step();
    ex_ready = 1'b0;
    applyStimulus(6'h00, 5'd7, 5'd8, 16'h0, 1'b1, 1'b0, 1'b1, 32'h200);
    #1;
    checkOutput("stall id_ready", {31'b0, id_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) setWriteBack(1'b1, 5'd9, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0);
      else wb_valid = 1'b0;
      step();
      checkOutput($sformatf("stall%0d ex_valid", c), {31'b0, ex_valid}, 32'h1);
      checkOutput($sformatf("stall%0d pc_plus4", c), ex_pc_plus4, 32'h100);
      checkOutput($sformatf("stall%0d read_data_1", c), ex_read_data_1, 32'h1234);
      checkOutput($sformatf("stall%0d id_ready", c), {31'b0, id_ready}, 32'h0);
    end
    checkOutput("stall refresh rt", ex_read_data_2, 32'h55);
    ex_ready = 1'b1;
    #1;
    checkOutput("release id_ready", {31'b0, id_ready}, 32'h1);
    step();
    checkOutput("release pc_plus4", ex_pc_plus4, 32'h200);
    checkOutput("release read_data_1", ex_read_data_1, 32'hDEADBEEF);
    checkOutput("release read_data_2", ex_read_data_2, 32'hCAFE);

    // Flush while stalled
    ex_ready = 1'b0;
    flush = 1'b1;
    step();
    checkOutput("flush ex_valid", {31'b0, ex_valid}, 32'h0);
    flush = 1'b0;
    ex_ready = 1'b1;

    // Asynchronous reset mid-stall, no clock edge needed
    applyStimulus(6'h0F, 5'd5, 5'd9, 16'h1234, 1'b0, 1'b0, 1'b1, 32'h300);
    step();
    checkOutput("pre-reset read_data_1", ex_read_data_1, 32'h1234);
    ex_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset ex_valid", {31'b0, ex_valid}, 32'h0);
    checkOutput("async reset read_data_1", ex_read_data_1, 32'h0);
    checkOutput("async reset read_data_2", ex_read_data_2, 32'h0);
    checkOutput("async reset imm_ext", ex_imm_ext, 32'h0);
    #1;
    reset = 1'b0;
    ex_ready = 1'b1;
    applyStimulus(6'h00, 5'd5, 5'd31, 16'h0, 1'b1, 1'b0, 1'b1, 32'h400);
    step();
    checkOutput("regfile cleared $5", ex_read_data_1, 32'h0);
    checkOutput("regfile cleared $31", ex_read_data_2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decode_regfile_pipe.md
Name: decode_regfile_pipe

Overview:
- Parametrised next-generation decode stage for the MIPS-style CPU.
- Contains an internal register file with one write-back port, two read ports, optional write-to-read bypass and $0 hardwired to zero.
- Decodes immediates per opcode: sign-extend, zero-extend for logical ops, or LUI shift.
- Registers operands and controls into an ID/EX pipeline register with valid/ready handshake, flush, and stall-time operand refresh.

Parameters:
- DATA_WIDTH, 32, width of register/data words (≥16).
- REG_ADDR_WIDTH, 5, register address width; register count = 2**REG_ADDR_WIDTH.
- LINK_REG, 31, destination register forced for JAL.
- BYPASS, 1, 1 = same-cycle write data is visible on reads; 0 = reads see the array only.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  fetch presents a valid instruction
- id_ready  out  1  decode accepts the instruction this cycle
- id_instruction  in  32  instruction word: rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], opcode=[31:26]
- id_pc_plus4  in  DATA_WIDTH  PC+4 of the instruction
- id_reg_dst  in  1  destination select: 1 = rd, 0 = rt
- id_jal  in  1  JAL; destination is LINK_REG
- id_reg_write  in  1  instruction writes a register
- flush  in  1  kill the ID/EX contents
- wb_valid  in  1  write-back slot valid
- wb_reg_write  in  1  write-back writes a register
- wb_mem_to_reg  in  1  write data source: 1 = wb_mem_data, 0 = wb_alu_result
- wb_jal  in  1  write data = wb_pc_plus4 (overrides wb_mem_to_reg)
- wb_addr  in  REG_ADDR_WIDTH  write-back destination
- wb_alu_result, wb_mem_data, wb_pc_plus4  in  DATA_WIDTH  write-back data sources
- ex_valid  out  1  ID/EX slot holds a valid instruction
- ex_ready  in  1  EX consumes the slot this cycle
- ex_read_data_1, ex_read_data_2  out  DATA_WIDTH  rs and rt operands
- ex_imm_ext  out  DATA_WIDTH  decoded immediate
- ex_rs, ex_rt, ex_write_addr  out  REG_ADDR_WIDTH  source addresses and resolved destination
- ex_reg_write  out  1  registered id_reg_write (forced 0 when the resolved destination is 0)
- ex_pc_plus4  out  DATA_WIDTH  registered PC+4

Behaviour:
- Reset (asynchronous): all registers including $0 = 0; ex_valid = 0; all ex_* outputs = 0.
- Write port:
  - we = wb_valid & wb_reg_write & (wb_addr != 0).
  - wdata = wb_jal ? wb_pc_plus4 : wb_mem_to_reg ? wb_mem_data : wb_alu_result.
  - The array is written at the rising edge when we = 1.
- Read (combinational from id_instruction):
  - Address 0 always reads 0.
  - With BYPASS = 1, if we and wb_addr equals the read address, the read returns wdata.
- Immediate decode:
  - Opcodes 0x0C, 0x0D, 0x0E: zero-extend imm.
  - Opcode 0x0F: imm in bits [31:16], lower bits 0; when DATA_WIDTH > 32, bits above 31 are sign-extended from imm[15].
  - All other opcodes: sign-extend imm[15].
- Destination resolution: id_jal → LINK_REG; else id_reg_dst → rd; else rt.
- Handshake: id_ready = !ex_valid | ex_ready (combinational, ignores flush).
- Rising-edge priority:
  1. flush = 1: ex_valid ← 0; payload may hold.
  2. Else if id_ready: ex_valid ← id_valid; payload loads when id_valid = 1.
  3. Else (stall): payload holds.
- Stall refresh: while ex_valid & !ex_ready, if we and wb_addr == ex_rs (ex_rs != 0), ex_read_data_1 ← wdata at the edge. The same rule applies to ex_rt and ex_read_data_2. Held operands therefore never go stale.
- Latency: one cycle from id accept to ex_valid.
- Throughput: one instruction per cycle when ex_ready = 1.
- Simultaneous write-back and read of the same register: with BYPASS = 1 the new value is captured; with BYPASS = 0 the old value is captured.
- Reset asserted mid-stall clears the slot immediately, with no edge required.

Test Plan:
- Reset, then wb write $5 = 0x1234, then decode rs=5, rt=0 → ex_read_data_1 = 0x1234, ex_read_data_2 = 0; an attempted write to $0 leaves $0 reading 0.
- Same-cycle write $7 = 0xDEADBEEF with decode rs=7: BYPASS = 1 → 0xDEADBEEF; BYPASS = 0 → previous value 0.
- imm = 0x8001 with opcode 0x08 → 0xFFFF8001; opcode 0x0D → 0x00008001; opcode 0x0F → 0x80010000.
- JAL with wb_jal, wb_pc_plus4 = 0x400 → $31 = 0x400; decode with id_jal → ex_write_addr = 31.
- Stall: hold ex_ready = 0 for 3 cycles with id_valid = 1 → id_ready = 0 and the slot is unchanged. A wb write to ex_rt with 0x55 during the stall → ex_read_data_2 = 0x55. Releasing ex_ready accepts the next instruction next cycle.
- flush while stalled → ex_valid = 0 next edge; asynchronous reset mid-stream → ex_valid = 0 and operands = 0 immediately.
